// File: rtl/ifmap_pkt_rx.sv
// Ifmap NoC receive node: filters packets, reassembles one row in any column
// order, then streams the completed row to the PE in column order.
module ifmap_pkt_rx #(
    parameter int         WIDTH_DATA = 13,
    parameter int         WIDTH_I    = 25,
    parameter logic [7:0] MY_ADDR    = 8'h00,
    parameter logic [1:0] DATA_TYPE  = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    output logic                  pkt_ready,
    input  logic [31:0]           pkt_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH_DATA-1:0] out_data,
    output logic [7:0]            out_col,
    output logic                  out_last,
    output logic                  row_done,
    output logic                  err_drop,
    output logic [7:0]            row_count
);

    localparam int         IDX_W    = (WIDTH_I > 1) ? $clog2(WIDTH_I) : 1;
    localparam logic [7:0] NUM_COL  = 8'(WIDTH_I);
    localparam logic [7:0] LAST_COL = 8'(WIDTH_I - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                 state;
    logic [WIDTH_I-1:0]     bitmap;
    logic [WIDTH_I-1:0]     col_onehot;
    logic [WIDTH_DATA-1:0]  row_buf [WIDTH_I];
    logic [7:0]             rd_ptr;

    logic                   pkt_rsvd;
    logic [1:0]             pkt_type;
    logic [7:0]             pkt_dst;
    logic [7:0]             pkt_col;
    logic [WIDTH_DATA-1:0]  pkt_val;
    logic [IDX_W-1:0]       col_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic                   col_in_range;
    logic                   pkt_accept;
    logic                   pkt_drop;
    logic                   pkt_write;
    logic                   row_full;

    assign pkt_rsvd = pkt_data[31];
    assign pkt_type = pkt_data[30:29];
    assign pkt_dst  = pkt_data[28:21];
    assign pkt_col  = pkt_data[20:13];
    assign pkt_val  = pkt_data[WIDTH_DATA-1:0];
    assign col_idx  = pkt_col[IDX_W-1:0];
    assign rd_idx   = rd_ptr[IDX_W-1:0];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        col_onehot   = '0;
        col_in_range = (pkt_col < NUM_COL);
        if (col_in_range) col_onehot[col_idx] = 1'b1;
        pkt_accept = pkt_valid && (state == FILL);
        pkt_drop   = pkt_rsvd || (pkt_type != DATA_TYPE) || (pkt_dst != MY_ADDR) ||
                     !col_in_range || (|(bitmap & col_onehot));
        pkt_write  = pkt_accept && !pkt_drop;
        row_full   = &(bitmap | col_onehot);
    end

    assign pkt_ready = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign out_col   = rd_ptr;
    assign out_last  = (rd_ptr == LAST_COL);
    assign out_data  = row_buf[rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            bitmap    <= '0;
            rd_ptr    <= '0;
            row_count <= '0;
            row_done  <= 1'b0;
            err_drop  <= 1'b0;
        end else begin
            err_drop <= pkt_accept && pkt_drop;
            row_done <= 1'b0;
            case (state)
                FILL: begin
                    if (pkt_write) begin
                        bitmap <= bitmap | col_onehot;
                        if (row_full) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            rd_ptr    <= '0;
                            bitmap    <= '0;
                            row_count <= row_count + 8'd1;
                            row_done  <= 1'b1;
                            state     <= FILL;
                        end else begin
                            rd_ptr <= rd_ptr + 8'd1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // NOTE: the row buffer is deliberately not reset; the bitmap alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (pkt_write) row_buf[col_idx] <= pkt_val;
    end

endmodule

// File: tb/tb_ifmap_pkt_rx.sv
// Directed bench for ifmap_pkt_rx: a reference row model feeds a scoreboard
// of expected output words that is checked as the row drains.
module tb_ifmap_pkt_rx;

    localparam int         W    = 25;
    localparam logic [7:0] ADDR = 8'h08;

    typedef struct packed {
        logic [7:0]  col;
        logic [12:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_data;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_data;
    logic [7:0]  out_col;
    logic        out_last;
    logic        row_done;
    logic        err_drop;
    logic [7:0]  row_count;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_buf [W];
    bit          m_bmp [W];
    int          m_rc = 0;
    int          drop_seen = 0;
    word_t       sb [$];

    ifmap_pkt_rx #(
        .WIDTH_DATA(13),
        .WIDTH_I   (W),
        .MY_ADDR   (ADDR),
        .DATA_TYPE (2'b01)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready),
        .pkt_data (pkt_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_col  (out_col),
        .out_last (out_last),
        .row_done (row_done),
        .err_drop (err_drop),
        .row_count(row_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input bit r, input logic [1:0] t, input logic [7:0] d,
                                       input logic [7:0] c, input logic [12:0] v);
        return {r, t, d, c, v};
    endfunction

    // Reference filter and row assembly; a completed row is queued in column order.
    task automatic model_accept(input logic [31:0] p, output bit drop, output bit full);
        logic [7:0] c;
        c    = p[20:13];
        drop = p[31] || (p[30:29] != 2'b01) || (p[28:21] != ADDR) || (c >= 8'(W));
        if (!drop) drop = m_bmp[c];
        full = 1'b0;
        if (!drop) begin
            m_buf[c] = p[12:0];
            m_bmp[c] = 1'b1;
            full = 1'b1;
            for (int i = 0; i < W; i++) if (!m_bmp[i]) full = 1'b0;
        end
        if (full) begin
            for (int i = 0; i < W; i++) begin
                sb.push_back('{col: 8'(i), data: m_buf[i]});
                m_bmp[i] = 1'b0;
            end
        end
    endtask

    task automatic send_pkt(input logic [31:0] p);
        bit drop, full;
        int n;
        n = 0;
        pkt_data  = p;
        pkt_valid = 1'b1;
        while (!pkt_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("pkt_ready_wait", {31'd0, pkt_ready}, 32'd1);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        model_accept(p, drop, full);
        if (err_drop) drop_seen++;
        check("err_drop", {31'd0, err_drop}, {31'd0, drop});
        check("out_valid_after_pkt", {31'd0, out_valid}, {31'd0, full});
        check("pkt_ready_after_pkt", {31'd0, pkt_ready}, {31'd0, !full});
    endtask

    // Drains one row; optionally stalls on word 0, or stops before transferring word stop_at.
    task automatic drain_row(input int stall_cycles, input int stop_at);
        word_t exp;
        int n;
        check("sb_size", sb.size(), W);
        out_ready = 1'b1;
        for (int i = 0; i < W; i++) begin
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            check("out_valid", {31'd0, out_valid}, 32'd1);
            if (i == stop_at) begin
                out_ready = 1'b0;
                check("stop_col", {24'd0, out_col}, stop_at);
                return;
            end
            exp = (sb.size() > 0) ? sb.pop_front() : '0;
            check("out_col", {24'd0, out_col}, {24'd0, exp.col});
            check("out_data", {19'd0, out_data}, {19'd0, exp.data});
            check("out_last", {31'd0, out_last}, {31'd0, exp.col == 8'(W - 1)});
            check("pkt_ready_drain", {31'd0, pkt_ready}, 32'd0);
            if (i == 0 && stall_cycles > 0) begin
                out_ready = 1'b0;
                repeat (stall_cycles) begin
                    @(posedge clk); #1;
                    check("stall_col", {24'd0, out_col}, {24'd0, exp.col});
                    check("stall_data", {19'd0, out_data}, {19'd0, exp.data});
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                    check("stall_pkt_ready", {31'd0, pkt_ready}, 32'd0);
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        m_rc++;
        check("row_done", {31'd0, row_done}, 32'd1);
        check("row_count", {24'd0, row_count}, m_rc & 255);
        check("out_valid_end", {31'd0, out_valid}, 32'd0);
        check("pkt_ready_end", {31'd0, pkt_ready}, 32'd1);
    endtask

    initial begin
        bit drop, full;
        logic [31:0] p;
        int drops_before;

        for (int i = 0; i < W; i++) m_bmp[i] = 1'b0;
        rst       = 1'b1;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_row_count", {24'd0, row_count}, 32'd0);
        check("rst_row_done", {31'd0, row_done}, 32'd0);
        check("rst_err_drop", {31'd0, err_drop}, 32'd0);

        // Row sent in column order.
        for (int c = 0; c < W; c++) send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'(c + 100)));
        drain_row(0, -1);

        // Row sent in reverse order.
        drops_before = drop_seen;
        for (int c = W - 1; c >= 0; c--) send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'h1FFF - 13'(c)));
        check("reverse_no_drop", drop_seen - drops_before, 0);
        drain_row(0, -1);

        // Filtered packets interleaved inside a valid row.
        drops_before = drop_seen;
        for (int c = 0; c < W; c++) begin
            send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'(c * 7)));
            if (c == 5)  send_pkt(mk(1'b0, 2'b01, 8'h10, 8'(c + 1), 13'h0111));
            if (c == 10) send_pkt(mk(1'b0, 2'b10, ADDR, 8'(c + 1), 13'h0222));
            if (c == 15) send_pkt(mk(1'b1, 2'b01, ADDR, 8'(c + 1), 13'h0333));
            if (c == 20) send_pkt(mk(1'b0, 2'b01, ADDR, 8'd25, 13'h0444));
        end
        check("filter_drops", drop_seen - drops_before, 4);
        drain_row(0, -1);

        // Duplicate column: the first write must win.
        drops_before = drop_seen;
        for (int c = 0; c < W; c++) begin
            send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), (c == 3) ? 13'd5 : 13'(c + 300)));
            if (c == 3) send_pkt(mk(1'b0, 2'b01, ADDR, 8'd3, 13'd9));
        end
        check("dup_drops", drop_seen - drops_before, 1);
        drain_row(0, -1);

        // Backpressure, with the next row's first packet waiting on the NoC side.
        for (int c = 0; c < W; c++) send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'(c * 3)));
        p = mk(1'b0, 2'b01, ADDR, 8'd0, 13'd77);
        pkt_data  = p;
        pkt_valid = 1'b1;
        drain_row(10, -1);
        @(posedge clk); #1;
        pkt_valid = 1'b0;
        model_accept(p, drop, full);
        check("held_pkt_err_drop", {31'd0, err_drop}, {31'd0, drop});
        check("held_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        for (int c = 1; c < W; c++) send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'(c + 500)));
        drain_row(0, -1);

        // Reset while draining at column 7, then a fresh row.
        for (int c = 0; c < W; c++) send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'(c) ^ 13'h0AAA));
        drain_row(0, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_rc = 0;
        for (int i = 0; i < W; i++) m_bmp[i] = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_row_count", {24'd0, row_count}, 32'd0);
        check("midrst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
        check("midrst_row_done", {31'd0, row_done}, 32'd0);
        for (int c = W - 1; c >= 0; c--) send_pkt(mk(1'b0, 2'b01, ADDR, 8'(c), 13'(c + 1000)));
        drain_row(0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
